// File: rtl/simd2_semiring_pkg.sv
// Semiring definitions shared by the dot-product pipeline: mode encoding and the
// lane multiply (x), reduce (+) and (+)-identity operators.
package simd2_semiring_pkg;

  localparam int SR_WMAX = 32;

  typedef enum logic [1:0] {
    MAXMIN  = 2'd0,
    MINMAX  = 2'd1,
    MINPLUS = 2'd2,
    MAXPLUS = 2'd3
  } mode_e;

  typedef logic [SR_WMAX-1:0] sr_word_t;

  // Operators work on zero-extended words; w gives the real lane width (w <= SR_WMAX).
  function automatic sr_word_t sat_max(input int w);
    logic [SR_WMAX:0] one_w;
    one_w = {{SR_WMAX{1'b0}}, 1'b1};
    return sr_word_t'((one_w << w) - one_w);
  endfunction

  function automatic sr_word_t otimes(input mode_e mode, input sr_word_t a, input sr_word_t b,
                                      input int w, output logic sat);
    logic [SR_WMAX:0] sum;
    sr_word_t         lim;
    sr_word_t         res;
    sum = {1'b0, a} + {1'b0, b};
    lim = sat_max(w);
    sat = 1'b0;
    case (mode)
      MAXMIN:  res = (a < b) ? a : b;
      MINMAX:  res = (a > b) ? a : b;
      MINPLUS, MAXPLUS: begin
        if (sum > {1'b0, lim}) begin
          res = lim;
          sat = 1'b1;
        end else begin
          res = sum[SR_WMAX-1:0];
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic sr_word_t oplus(input mode_e mode, input sr_word_t x, input sr_word_t y);
    sr_word_t res;
    case (mode)
      MAXMIN, MAXPLUS: res = (x > y) ? x : y;
      MINMAX, MINPLUS: res = (x < y) ? x : y;
      default:         res = '0;
    endcase
    return res;
  endfunction

  function automatic sr_word_t oplus_id(input mode_e mode, input int w);
    sr_word_t res;
    case (mode)
      MINMAX, MINPLUS: res = sat_max(w);
      default:         res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/semiring_lane.sv
// One lane of the (x) stage: registered semiring multiply with a clip flag.
module semiring_lane
  import simd2_semiring_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  mode_e        i_mode,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_res,
  output logic         o_sat
);

  logic [W-1:0] w_res;
  logic         w_sat;
  logic [W-1:0] r_res;
  logic         r_sat;

  // Lane operator for the current mode.
  always_comb begin
    w_sat = 1'b0;
    w_res = W'(otimes(i_mode, sr_word_t'(i_a), sr_word_t'(i_b), W, w_sat));
  end

  // Lane result register; holds when the pipeline stalls or carries a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res <= '0;
      r_sat <= 1'b0;
    end else if (i_en) begin
      r_res <= w_res;
      r_sat <= w_sat;
    end
  end

  assign o_res = r_res;
  assign o_sat = r_sat;

endmodule

// File: rtl/semiring_dot_pipe.sv
// Pipelined K-lane semiring dot product: input register, lane (x), one (+) tree level
// per stage, and a last stage that combines the final tree level with the c fold.
module semiring_dot_pipe
  import simd2_semiring_pkg::*;
#(
  parameter int W = 16,
  parameter int K = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     in_mode,
  input  logic           in_acc_en,
  input  logic [K*W-1:0] in_a,
  input  logic [K*W-1:0] in_b,
  input  logic [W-1:0]   in_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_sat
);

  localparam int L   = $clog2(K);
  localparam int LAT = L + 2;

  // Tree nodes are stored level after level; level lv starts at this index.
  function automatic int lvl_off(input int lv);
    return (2 * K) - ((2 * K) >> lv);
  endfunction

  logic           w_adv;
  logic [K*W-1:0] r_a;
  logic [K*W-1:0] r_b;
  logic [L:0]     r_valid;
  logic [L:0]     r_acc;
  logic [L:0]     r_sat;
  logic [W-1:0]   r_c    [L+1];
  mode_e          r_mode [L+1];
  logic [L:0]     w_sat_cur;
  logic [K-1:0]   w_lane_sat;
  logic [W-1:0]   w_node [2*K-2];
  logic [W-1:0]   w_red  [K-1];
  logic [W-1:0]   w_base;
  logic [W-1:0]   w_fold;
  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic           r_out_sat;

  assign w_adv    = !r_out_valid || out_ready;
  assign in_ready = w_adv;

  // Input capture and per-stage sideband (valid, mode, acc_en, c, sat) shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= '0;
      r_acc   <= '0;
      r_sat   <= '0;
      for (int s = 0; s <= L; s++) begin
        r_c[s]    <= '0;
        r_mode[s] <= MAXMIN;
      end
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      if (in_valid) begin
        r_a       <= in_a;
        r_b       <= in_b;
        r_mode[0] <= mode_e'(in_mode);
        r_acc[0]  <= in_acc_en;
        r_c[0]    <= in_c;
        r_sat[0]  <= 1'b0;
      end
      for (int s = 1; s <= L; s++) begin
        r_valid[s] <= r_valid[s-1];
        if (r_valid[s-1]) begin
          r_mode[s] <= r_mode[s-1];
          r_acc[s]  <= r_acc[s-1];
          r_c[s]    <= r_c[s-1];
          r_sat[s]  <= w_sat_cur[s-1];
        end
      end
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_lane
    semiring_lane #(.W(W)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (w_adv && r_valid[0]),
      .i_mode (r_mode[0]),
      .i_a    (r_a[g*W +: W]),
      .i_b    (r_b[g*W +: W]),
      .o_res  (w_node[g]),
      .o_sat  (w_lane_sat[g])
    );
  end

  // Lane clip flags join the transaction's sat bit as it leaves the lane stage.
  always_comb begin
    w_sat_cur = r_sat;
    w_sat_cur[1] = r_sat[1] | (|w_lane_sat);
  end

  for (genvar lv = 1; lv <= L; lv++) begin : g_lvl
    for (genvar j = 0; j < (K >> lv); j++) begin : g_node
      localparam int SRC = lvl_off(lv - 1) + 2 * j;
      localparam int DST = lvl_off(lv) - K + j;
      assign w_red[DST] = W'(oplus(r_mode[lv], sr_word_t'(w_node[SRC]), sr_word_t'(w_node[SRC+1])));
      if (lv < L) begin : g_reg
        logic [W-1:0] r_q;
        // Tree level register, loaded only when its source stage holds a transaction.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_q <= '0;
          end else if (w_adv && r_valid[lv]) begin
            r_q <= w_red[DST];
          end
        end
        assign w_node[lvl_off(lv) + j] = r_q;
      end
    end
  end

  // Final fold of c (or the (+)-identity); min/max cannot clip, so sat is unchanged.
  always_comb begin
    w_base = r_acc[L] ? r_c[L] : W'(oplus_id(r_mode[L], W));
    w_fold = W'(oplus(r_mode[L], sr_word_t'(w_red[K-2]), sr_word_t'(w_base)));
  end

  // Output register; frozen while the result waits on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      r_out_valid <= r_valid[L];
      if (r_valid[L]) begin
        r_out_data <= w_fold;
        r_out_sat  <= w_sat_cur[L];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

  localparam int UNUSED_LAT = LAT;

endmodule
